// File: rtl/shift_out_tx.sv
`timescale 1ns/1ps
// shift_out_tx: parallel-in, serial-out transmitter feeding a bit-serial shift chain.
// It accepts a WIDTH-bit word through a valid/ready load handshake.
// It presents one bit per Shift_En strobe, then pulses Done for one cycle.
// Ports:
//   Clk, Reset   - clock; asynchronous active-high reset
//   Load_Valid   - Data_In is valid this cycle
//   Load_Ready   - high in IDLE only
//   Data_In      - parallel word to send
//   Shift_En     - consumer strobe: the current bit was taken
//   Shift_Out    - current serial bit (0 outside SHIFT)
//   Shift_Valid  - Shift_Out carries a word bit (SHIFT only)
//   Busy         - high in SHIFT and DONE
//   Done         - one-cycle pulse after the last bit is consumed
module shift_out_tx #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load_Valid,
    output logic             Load_Ready,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Shift_En,
    output logic             Shift_Out,
    output logic             Shift_Valid,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] shifted;

    // Move the next bit into the output end, filling with 0.
    assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_reg[WIDTH-1:1]};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        unique case (state)
            ST_IDLE: begin
                if (Load_Valid) begin
                    shift_nxt = Data_In;
                    cnt_nxt   = '0;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (Shift_En) begin
                    // The final strobe leaves the register as is; the word is spent.
                    if (bit_cnt == LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        shift_nxt = shifted;
                        cnt_nxt   = bit_cnt + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign Load_Ready  = (state == ST_IDLE);
    assign Shift_Valid = (state == ST_SHIFT);
    assign Busy        = (state == ST_SHIFT) || (state == ST_DONE);
    assign Done        = (state == ST_DONE);
    assign Shift_Out   = Shift_Valid &
                         (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);

endmodule

// File: tb/tb_shift_out_tx.sv
`timescale 1ns/1ps
// Bench for shift_out_tx: LSB-first and MSB-first instances share one stimulus.
// A word/bit-index model predicts every output; directed cases pin literal sequences.
module tb_shift_out_tx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         lv  = 1'b0;
    logic         se  = 1'b0;
    logic [W-1:0] din = '0;

    logic lr_a, so_a, sv_a, busy_a, done_a;
    logic lr_b, so_b, sv_b, busy_b, done_b;

    always #5 clk = ~clk;

    shift_out_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_a (
        .Clk(clk), .Reset(rst), .Load_Valid(lv), .Load_Ready(lr_a),
        .Data_In(din), .Shift_En(se), .Shift_Out(so_a),
        .Shift_Valid(sv_a), .Busy(busy_a), .Done(done_a)
    );

    shift_out_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_b (
        .Clk(clk), .Reset(rst), .Load_Valid(lv), .Load_Ready(lr_b),
        .Data_In(din), .Shift_En(se), .Shift_Out(so_b),
        .Shift_Valid(sv_b), .Busy(busy_b), .Done(done_b)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // Model: phase 0=idle 1=sending 2=finished; word held whole, k = bits consumed.
    int           ph [2] = '{0, 0};
    logic [W-1:0] wd [2] = '{'0, '0};
    int           k  [2] = '{0, 0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i] = 0; wd[i] = '0; k[i] = 0;
            end else if (ph[i] == 0) begin
                if (lv) begin
                    wd[i] = din; k[i] = 0; ph[i] = 1;
                end
            end else if (ph[i] == 1) begin
                if (se) begin
                    if (k[i] == W - 1) ph[i] = 2;
                    else k[i] = k[i] + 1;
                end
            end else begin
                ph[i] = 0;
            end
        end
    end

    function automatic logic exp_so(int i);
        if (ph[i] != 1) return 1'b0;
        return (i == 1) ? wd[i][W-1-k[i]] : wd[i][k[i]];
    endfunction

    task automatic cmp_dut(int i, logic lr, logic so, logic sv,
                           logic bz, logic dn);
        string t;
        t = (i == 0) ? "lsb" : "msb";
        chk({t, ".load_ready"},  32'(lr), 32'(ph[i] == 0));
        chk({t, ".shift_valid"}, 32'(sv), 32'(ph[i] == 1));
        chk({t, ".busy"},        32'(bz), 32'(ph[i] != 0));
        chk({t, ".done"},        32'(dn), 32'(ph[i] == 2));
        chk({t, ".shift_out"},   32'(so), 32'(exp_so(i)));
    endtask

    always @(negedge clk) begin
        cmp_dut(0, lr_a, so_a, sv_a, busy_a, done_a);
        cmp_dut(1, lr_b, so_b, sv_b, busy_b, done_b);
    end

    // Capture of consumed bits and handshake timing.
    bit qa[$];
    bit qb[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_edge = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sv_a && se) qa.push_back(so_a);
        if (sv_b && se) qb.push_back(so_b);
        if (done_a) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (lv && lr_a && !rst) acc_edge = cyc + 1;
    end

    function automatic logic [31:0] pack(bit q[$]);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
        return v;
    endfunction

    task automatic clear_cap();
        qa.delete();
        qb.delete();
        done_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(logic [W-1:0] w);
        int t;
        t   = 0;
        din = w;
        lv  = 1'b1;
        while (!lr_a && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) chk("load_timeout", 0, 1);
        tick();
        lv = 1'b0;
    endtask

    task automatic wait_done(int lim);
        int t;
        t = 0;
        while (!done_a && t < lim) begin
            tick();
            t++;
        end
        if (t >= lim) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #2;
        chk("rst.load_ready",  32'(lr_a),   1);
        chk("rst.shift_valid", 32'(sv_a),   0);
        chk("rst.busy",        32'(busy_a), 0);
        chk("rst.done",        32'(done_a), 0);
        chk("rst.shift_out",   32'(so_a),   0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Continuous strobes, A5C3.
        clear_cap();
        se = 1'b1;
        do_load(16'hA5C3);
        wait_done(40);
        tick();
        se = 1'b0;
        chk("t1.lsb_bits",   pack(qa), 32'h0000_A5C3);
        chk("t1.msb_bits",   pack(qb), 32'h0000_C3A5);
        chk("t1.nbits",      qa.size(), 16);
        chk("t1.done_cnt",   done_cnt, 1);
        chk("t1.done_delay", done_cyc - acc_edge, W);

        // Strobe every third cycle, 8001.
        clear_cap();
        do_load(16'h8001);
        for (int s = 0; s < W; s++) begin
            tick();
            tick();
            se = 1'b1;
            tick();
            se = 1'b0;
        end
        wait_done(10);
        tick();
        chk("t2.msb_bits", pack(qb), 32'h0000_8001);
        chk("t2.lsb_bits", pack(qa), 32'h0000_8001);
        chk("t2.nbits",    qb.size(), 16);
        chk("t2.done_cnt", done_cnt, 1);

        // Load attempt while shifting is ignored.
        clear_cap();
        do_load(16'h1234);
        din = 16'hFFFF;
        lv  = 1'b1;
        repeat (4) tick();
        lv = 1'b0;
        se = 1'b1;
        wait_done(40);
        tick();
        se = 1'b0;
        chk("t3.lsb_bits", pack(qa), 32'h0000_1234);
        chk("t3.done_cnt", done_cnt, 1);

        // Asynchronous abort after five bits, then a fresh word.
        clear_cap();
        se = 1'b1;
        do_load(16'h00FF);
        repeat (5) tick();
        se = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("t4.abort_sv",   32'(sv_a),   0);
        chk("t4.abort_busy", 32'(busy_a), 0);
        chk("t4.abort_lr",   32'(lr_a),   1);
        chk("t4.abort_so",   32'(so_a),   0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t4.no_done", done_cnt, 0);
        chk("t4.partial", qa.size(), 5);
        clear_cap();
        se = 1'b1;
        do_load(16'h0003);
        wait_done(40);
        tick();
        se = 1'b0;
        chk("t4.fresh_bits", pack(qa), 32'h0000_0003);
        chk("t4.done_cnt",   done_cnt, 1);

        // Back-to-back loads with Load_Valid held.
        clear_cap();
        se  = 1'b1;
        din = 16'h0001;
        lv  = 1'b1;
        tick();
        din = 16'h0002;
        wait_done(40);
        tick();
        tick();
        lv = 1'b0;
        wait_done(40);
        tick();
        se = 1'b0;
        chk("t5.bits",     pack(qa), 32'h0002_0001);
        chk("t5.nbits",    qa.size(), 32);
        chk("t5.done_cnt", done_cnt, 2);

        // Strobes in IDLE do nothing.
        clear_cap();
        se = 1'b1;
        repeat (10) tick();
        se = 1'b0;
        chk("t6.nbits",    qa.size(), 0);
        chk("t6.done_cnt", done_cnt, 0);

        // Random traffic with occasional asynchronous aborts.
        for (int c = 0; c < 3000; c++) begin
            lv  = ($urandom_range(0, 3) == 0);
            din = W'($urandom);
            se  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #4 rst = 1'b0;
            end
            tick();
        end
        lv = 1'b0;
        se = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
